// File: rtl/cpu_defs_pkg.sv
// Shared CPU front-end types: pipeline flush request, BPU prediction result,
// and the PC generator state encoding and reset vector.
package cpu_defs;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    typedef struct packed {
        logic ex;
        logic eret;
        logic tlb_op;
    } pipeline_flush_t;

    typedef struct packed {
        logic        valid;
        logic        br_taken;
        logic [31:0] target;
    } predict_result_t;

    typedef enum logic [1:0] {
        SEQ     = 2'd0,
        WAIT_DS = 2'd1,
        CORR    = 2'd2
    } pc_gen_state_t;

endpackage

// File: rtl/pc_gen.sv
// Next-PC generator: owns the fetch PC, issues I-cache requests and applies
// flush, mispredict-correction and taken-branch redirects (MIPS delay slot aware).
module pc_gen
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  pipeline_flush_t pipeline_flush,
    input  logic [31:0]     flush_target,
    input  predict_result_t bpu_predict_bus,
    input  logic [31:0]     ds_pc,
    input  logic            bpu_flush,
    input  logic [31:0]     correct_target,
    input  logic            fs_allowin,
    input  logic            inst_addr_ok,
    output logic            inst_req,
    output logic [31:0]     inst_addr,
    output logic            kill_fetch,
    output logic            correct_finish
);

    pc_gen_state_t state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   pend_target_q, pend_target_d;
    logic          accept_s;
    logic          taken_s;
    logic          at_ds_s;

    assign inst_req  = ~reset & fs_allowin;
    assign inst_addr = pc_q;
    assign accept_s  = inst_req & inst_addr_ok;
    assign taken_s   = bpu_predict_bus.valid & bpu_predict_bus.br_taken;
    // pc still pointing at the delay slot means the slot has not been issued yet
    assign at_ds_s   = (pc_q == (ds_pc + 32'd4));

    // Next-state, next-PC and pulse outputs in event-priority order
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        pend_target_d  = pend_target_q;
        kill_fetch     = 1'b0;
        correct_finish = 1'b0;
        if (reset) begin
            state_d       = SEQ;
            pc_d          = RESET_PC;
            pend_target_d = 32'd0;
        end else if (|pipeline_flush) begin
            state_d       = SEQ;
            pc_d          = flush_target;
            pend_target_d = 32'd0;
        end else if (bpu_flush) begin
            state_d       = CORR;
            pc_d          = correct_target;
            pend_target_d = 32'd0;
            kill_fetch    = 1'b1;
        end else begin
            case (state_q)
                SEQ: begin
                    if (taken_s) begin
                        if (at_ds_s && accept_s) begin
                            pc_d = bpu_predict_bus.target;
                        end else if (at_ds_s) begin
                            pend_target_d = bpu_predict_bus.target;
                            state_d       = WAIT_DS;
                        end else begin
                            pc_d       = bpu_predict_bus.target;
                            kill_fetch = 1'b1;
                        end
                    end else if (accept_s) begin
                        pc_d = pc_q + 32'd4;
                    end else begin
                        pc_d = pc_q;
                    end
                end
                WAIT_DS: begin
                    if (accept_s) begin
                        pc_d    = pend_target_q;
                        state_d = SEQ;
                    end else begin
                        pc_d = pc_q;
                    end
                end
                CORR: begin
                    if (accept_s) begin
                        correct_finish = 1'b1;
                        pc_d           = pc_q + 32'd4;
                        state_d        = SEQ;
                    end else begin
                        pc_d = pc_q;
                    end
                end
                default: begin
                    state_d = SEQ;
                end
            endcase
        end
    end

    // State, PC and pending-target registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= SEQ;
            pc_q          <= RESET_PC;
            pend_target_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: inputs change 1ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_pc_gen;
    import cpu_defs::*;

    logic            clk;
    logic            reset;
    pipeline_flush_t pipeline_flush;
    logic [31:0]     flush_target;
    predict_result_t bpu_predict_bus;
    logic [31:0]     ds_pc;
    logic            bpu_flush;
    logic [31:0]     correct_target;
    logic            fs_allowin;
    logic            inst_addr_ok;
    logic            inst_req;
    logic [31:0]     inst_addr;
    logic            kill_fetch;
    logic            correct_finish;

    int n_cmp = 0;
    int n_err = 0;

    pc_gen dut (
        .clk             (clk),
        .reset           (reset),
        .pipeline_flush  (pipeline_flush),
        .flush_target    (flush_target),
        .bpu_predict_bus (bpu_predict_bus),
        .ds_pc           (ds_pc),
        .bpu_flush       (bpu_flush),
        .correct_target  (correct_target),
        .fs_allowin      (fs_allowin),
        .inst_addr_ok    (inst_addr_ok),
        .inst_req        (inst_req),
        .inst_addr       (inst_addr),
        .kill_fetch      (kill_fetch),
        .correct_finish  (correct_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr_pulses();
        pipeline_flush  = '0;
        bpu_flush       = 1'b0;
        bpu_predict_bus = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr_pulses();
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Redirect through a pipeline flush; pc equals a in the following cycle
    task automatic jump(input logic [31:0] a);
        pipeline_flush.ex = 1'b1;
        flush_target      = a;
        fs_allowin        = 1'b1;
        inst_addr_ok      = 1'b1;
        step();
    endtask

    task automatic predict(input logic [31:0] ds, input logic [31:0] tgt);
        bpu_predict_bus.valid    = 1'b1;
        bpu_predict_bus.br_taken = 1'b1;
        bpu_predict_bus.target   = tgt;
        ds_pc                    = ds;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        clr_pulses();
        flush_target   = 32'd0;
        ds_pc          = 32'd0;
        correct_target = 32'd0;
        fs_allowin     = 1'b1;
        inst_addr_ok   = 1'b1;

        // Reset state
        sample();
        check("rst_req", inst_req, 1'b0);
        check("rst_kill", kill_fetch, 1'b0);
        check("rst_cf", correct_finish, 1'b0);
        step();
        sample();
        check("rst_addr", inst_addr, 32'hBFC0_0000);
        check("rst_req2", inst_req, 1'b0);
        step();
        reset = 1'b0;
        sample();
        check("first_req", inst_req, 1'b1);
        check("first_addr", inst_addr, 32'hBFC0_0000);
        step();
        sample();
        check("seq_4", inst_addr, 32'hBFC0_0004);
        step();
        sample();
        check("seq_8", inst_addr, 32'hBFC0_0008);

        // Taken prediction before the delay slot leaves -> WAIT_DS
        jump(32'h8000_0104);
        inst_addr_ok = 1'b0;
        predict(32'h8000_0100, 32'h8000_0400);
        sample();
        check("wds_addr", inst_addr, 32'h8000_0104);
        check("wds_kill", kill_fetch, 1'b0);
        step();
        inst_addr_ok = 1'b0;
        predict(32'h8000_0900, 32'h0000_1234);
        sample();
        check("wds_hold", inst_addr, 32'h8000_0104);
        check("wds_ign_kill", kill_fetch, 1'b0);
        step();
        inst_addr_ok = 1'b1;
        sample();
        check("wds_ds_issue", inst_addr, 32'h8000_0104);
        check("wds_ds_kill", kill_fetch, 1'b0);
        step();
        sample();
        check("wds_target", inst_addr, 32'h8000_0400);
        check("wds_tgt_kill", kill_fetch, 1'b0);

        // Delay slot leaving in the same cycle as the prediction
        jump(32'h8000_0104);
        predict(32'h8000_0100, 32'h8000_0600);
        sample();
        check("ds_now_kill", kill_fetch, 1'b0);
        step();
        sample();
        check("ds_now_tgt", inst_addr, 32'h8000_0600);

        // Delay slot already issued -> kill
        jump(32'h8000_010C);
        predict(32'h8000_0100, 32'h8000_0400);
        sample();
        check("late_kill", kill_fetch, 1'b1);
        step();
        sample();
        check("late_tgt", inst_addr, 32'h8000_0400);
        check("late_kill_end", kill_fetch, 1'b0);

        // Mispredict correction
        bpu_flush      = 1'b1;
        correct_target = 32'h8000_0200;
        sample();
        check("corr_kill", kill_fetch, 1'b1);
        check("corr_cf0", correct_finish, 1'b0);
        step();
        inst_addr_ok = 1'b0;
        predict(32'h8000_0900, 32'h0000_5678);
        for (int i = 0; i < 3; i++) begin
            sample();
            check("corr_hold", inst_addr, 32'h8000_0200);
            check("corr_hold_cf", correct_finish, 1'b0);
            check("corr_ign_kill", kill_fetch, 1'b0);
            step();
            inst_addr_ok = 1'b0;
        end
        inst_addr_ok = 1'b1;
        sample();
        check("corr_cf", correct_finish, 1'b1);
        check("corr_acc_addr", inst_addr, 32'h8000_0200);
        step();
        sample();
        check("corr_next", inst_addr, 32'h8000_0204);
        check("corr_cf_end", correct_finish, 1'b0);

        // Flush + bpu_flush + taken prediction in one cycle: flush wins
        pipeline_flush.ex = 1'b1;
        flush_target      = 32'hBFC0_0380;
        bpu_flush         = 1'b1;
        correct_target    = 32'h8000_0200;
        predict(32'h8000_0100, 32'h8000_0400);
        sample();
        check("mix_kill", kill_fetch, 1'b0);
        step();
        sample();
        check("mix_addr", inst_addr, 32'hBFC0_0380);
        check("mix_cf", correct_finish, 1'b0);
        step();
        sample();
        check("mix_seq", inst_addr, 32'hBFC0_0384);

        // Flush while in CORR
        bpu_flush      = 1'b1;
        correct_target = 32'h8000_0200;
        step();
        pipeline_flush.eret = 1'b1;
        flush_target        = 32'h8000_0500;
        sample();
        check("corr_flush_cf", correct_finish, 1'b0);
        step();
        sample();
        check("corr_flush_addr", inst_addr, 32'h8000_0500);
        check("corr_flush_cf2", correct_finish, 1'b0);

        // Stall during WAIT_DS
        jump(32'h8000_0104);
        fs_allowin = 1'b0;
        predict(32'h8000_0100, 32'h8000_0800);
        for (int i = 0; i < 4; i++) begin
            sample();
            check("stall_req", inst_req, 1'b0);
            check("stall_pc", inst_addr, 32'h8000_0104);
            step();
            fs_allowin = 1'b0;
        end
        fs_allowin = 1'b1;
        sample();
        check("stall_ds_req", inst_req, 1'b1);
        check("stall_ds", inst_addr, 32'h8000_0104);
        step();
        sample();
        check("stall_tgt", inst_addr, 32'h8000_0800);

        // Reset in the middle of WAIT_DS
        jump(32'h8000_0104);
        inst_addr_ok = 1'b0;
        predict(32'h8000_0100, 32'h8000_0700);
        step();
        reset = 1'b1;
        sample();
        check("midrst_req", inst_req, 1'b0);
        step();
        reset        = 1'b0;
        inst_addr_ok = 1'b1;
        sample();
        check("midrst_addr", inst_addr, 32'hBFC0_0000);
        step();
        sample();
        check("midrst_seq", inst_addr, 32'hBFC0_0004);

        // Wrap-around and misaligned target
        jump(32'hFFFF_FFFC);
        step();
        sample();
        check("wrap", inst_addr, 32'h0000_0000);
        jump(32'h8000_0002);
        sample();
        check("misalign", inst_addr, 32'h8000_0002);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
